// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared constants for the multiply/divide unit: operand width,
//               operation codes and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int c_WIDTH = 32;

    localparam logic [1:0] c_OP_MULT  = 2'b00;
    localparam logic [1:0] c_OP_MULTU = 2'b01;
    localparam logic [1:0] c_OP_DIV   = 2'b10;
    localparam logic [1:0] c_OP_DIVU  = 2'b11;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CALC  = 2'd1;
    localparam logic [1:0] c_ST_FIXUP = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// Module      : mdu_step
// Description : One radix-2 iteration: shift-add multiply or restoring divide
//               on a 2*WIDTH accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    always_comb begin
        w_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Partial remainder after the left shift can need WIDTH+1 bits.
        w_shl = acc[2*WIDTH-1:WIDTH-1];
        w_ge  = (w_shl >= {1'b0, opnd});
        w_sub = w_shl[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (w_ge) begin
                acc_next = {w_sub, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {w_shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {w_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32-cycle MIPS-style MULT/MULTU/DIV/DIVU with HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         r_state;
    logic [4:0]         r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_open;
    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_open   = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
        w_accept = start && w_open;
        w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
        w_a_neg  = w_signed && rs_val[WIDTH-1];
        w_b_neg  = w_signed && rt_val[WIDTH-1];
        w_a_mag  = w_a_neg ? (~rs_val + 1'b1) : rs_val;
        w_b_mag  = w_b_neg ? (~rt_val + 1'b1) : rt_val;
        w_prod   = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    end

    mdu_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div   (r_is_div),
        .acc      (r_acc),
        .opnd     (r_opnd),
        .acc_next (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 5'd0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                c_ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= c_ST_FIXUP;
                    end
                end
                c_ST_FIXUP: begin
                    r_state <= c_ST_DONE;
                    if (r_is_div && r_div0) begin
                        r_hi <= r_dividend;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_lo <= r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
                        r_hi <= r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                          : r_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: begin
                    // IDLE and DONE: a start here wins over any MTHI/MTLO write.
                    if (w_accept) begin
                        r_state    <= c_ST_CALC;
                        r_cnt      <= 5'd0;
                        r_is_div   <= op[1];
                        r_dividend <= rs_val;
                        r_div0     <= (rt_val == '0);
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        if (op[1]) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opnd <= w_b_mag;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                            r_opnd <= w_a_mag;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                        if (hi_we) begin
                            r_hi <= wdata;
                        end
                        if (lo_we) begin
                            r_lo <= wdata;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == c_ST_CALC) || (r_state == c_ST_FIXUP);
    assign done = (r_state == c_ST_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass;
    int n_total;

    mult_div_unit #(
        .WIDTH  (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi, lo} as defined by the MIPS semantics of each operation.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // mode: 0 plain, 1 extra start at cycle 10, 2 lo_we at cycle 5, 3 hi_we with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        logic [63:0] exp;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          ndone;
        int          lat;
        exp   = model(o, a, b);
        hi0   = hi;
        lo0   = lo;
        ndone = 0;
        lat   = 0;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        hi_we  = (mode == 3);
        wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        start  = 1'b0;
        hi_we  = 1'b0;
        op     = 2'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        check("busy_c1", {63'h0, busy}, 64'h1);
        check("hilo_hold", {hi, lo}, {hi0, lo0});
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                ndone++;
                lat = cyc;
                check("result", {hi, lo}, exp);
            end
            if (mode == 1 && cyc == 10) start = 1'b1;
            if (mode == 1 && cyc == 11) start = 1'b0;
            if (mode == 2 && cyc == 5) begin
                lo_we = 1'b1;
                wdata = $urandom;
            end
            if (mode == 2 && cyc == 6) begin
                lo_we = 1'b0;
                check("lo_we_busy", {32'h0, lo}, {32'h0, lo0});
            end
            @(negedge clk);
        end
        check("done_count", 64'(ndone), 64'd1);
        check("latency", 64'(lat), 64'd34);
    endtask

    initial begin
        int ndone;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_val  = '0;
        rt_val  = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_state", {60'h0, busy, done, 2'b00}, 64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);

        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {hi, lo}, {32'h1234, 32'h0});

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        check("mult_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(2'b11, 32'd100, 32'd0, 0);
        check("divu_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'h8000_0000, 32'h0, 0);
        run_op(2'b01, 32'd3, 32'd5, 1);
        check("restart_ign", {hi, lo}, {32'h0, 32'd15});
        run_op(2'b00, 32'h1234_5678, 32'h8765_4321, 2);
        run_op(2'b11, 32'h7777_0000, 32'h0000_0123, 3);

        // Reset in the middle of a DIV.
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b10;
        rs_val = 32'hFFFF_F000;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", {62'h0, busy, done}, 64'h0);
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("rst_no_done", 64'(ndone), 64'd0);
        run_op(2'b11, 32'd9, 32'd4, 0);
        check("divu_after", {hi, lo}, {32'd1, 32'd2});

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 7 == 3) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i % 5 == 1) a = 32'($urandom_range(0, 1000)) - 32'd500;
            run_op(2'($urandom_range(0, 3)), a, b, (i % 4 == 2) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_val  input  32  multiplicand or dividend (register file read data 1).
REQ-007 SHALL have port rt_val  input  32  multiplier or divisor (register file read data 2).
REQ-008 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-009 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-010 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port hi  output  32  HI register (MULT upper product, DIV remainder).
REQ-014 SHALL have port lo  output  32  LO register (MULT lower product, DIV quotient).

Function
REQ-015 SHALL use FSM states IDLE, CALC, FIXUP and DONE.
REQ-016 SHALL accept start only in IDLE or DONE, capturing op, rs_val and rt_val at that edge and moving to CALC with iteration counter 0.
REQ-017 SHALL ignore start while busy; operand changes after capture SHALL have no effect.
REQ-018 SHALL perform one radix-2 step per CALC cycle (shift-add multiply, restoring divide) on magnitudes, with 32 CALC cycles; the counter reaching 31 SHALL move the FSM to FIXUP.
REQ-019 SHALL apply sign correction in FIXUP for signed ops, write hi/lo at the FIXUP edge, and enter DONE.
REQ-020 SHALL assert done only in DONE, for exactly one cycle, with hi/lo already valid; the start-to-done latency SHALL be 34 cycles, where the cycle after the accepting edge is cycle 1.
REQ-021 SHALL assert busy in CALC and FIXUP only.
REQ-022 SHALL return from DONE to IDLE unless start is accepted in DONE, in which case it SHALL go to CALC.
REQ-023 SHALL set MULT/MULTU results to {hi,lo} = full 64-bit product, signed or unsigned per op.
REQ-024 SHALL truncate the DIV quotient toward zero and give the remainder the sign of the dividend; DIVU SHALL be unsigned.
REQ-025 SHALL produce, on divide by zero (either signedness), lo = 0xFFFFFFFF and hi = rs_val, with no exception.
REQ-026 SHALL produce, for DIV 0x80000000 / 0xFFFFFFFF, lo = 0x80000000 and hi = 0.
REQ-027 SHALL apply hi_we/lo_we only in IDLE or DONE; writes while busy SHALL be discarded.
REQ-028 SHALL give start priority over hi_we/lo_we asserted in the same cycle, discarding the writes.
REQ-029 SHALL leave hi/lo unchanged from start acceptance until the FIXUP edge.

Reset
REQ-030 SHALL, when rst is high at a clock edge, force state IDLE, counter 0, hi = 0, lo = 0, busy = 0 and done = 0.
REQ-031 SHALL abandon an in-flight operation on rst, with no hi/lo update and no done pulse.
REQ-032 SHALL give rst priority over start, hi_we and lo_we.

Structure
REQ-033 SHALL place the op encodings, FSM state encoding and WIDTH constant in shared package mdu_pkg.
REQ-034 SHALL implement the single combinational iteration step (add/subtract-and-shift) as sub-module mdu_step, instantiated once.
REQ-035 SHALL use an iteration counter no wider than 5 bits.

Verification
REQ-036 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001, done exactly 34 cycles after start.
REQ-037 SHALL cover MULT 0xFFFFFFFD (-3) x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-038 SHALL cover DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; and DIVU 100 / 0 -> lo = 0xFFFFFFFF, hi = 100.
REQ-039 SHALL cover start pulsed again at cycle 10 of a running MULTU 3 x 5 -> ignored, result hi = 0, lo = 15, a single done pulse.
REQ-040 SHALL cover rst at cycle 20 of a DIV -> busy = 0, hi = lo = 0 next cycle, no done; a new DIVU 9 / 4 then gives lo = 2, hi = 1.
REQ-041 SHALL cover hi_we with wdata 0x1234 in IDLE -> hi = 0x1234; lo_we during CALC -> lo unchanged until result.
